lut4_responder: RTL and testbench

LUT4_RESPONDER -- requirements
Module: lut4_responder

---
 rtl/lut4_responder.sv | 125 ++++++++++++
 tb/tb_lut4_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/lut4_responder.sv
// Purpose: 4-input lookup table loaded serially (16 bits, index 0 first), then
//          answers queries {a,b,c,d} with the stored bit and counts responses.
// Latency: 1 cycle from query handshake to y_o/y_valid_o.
// Backpressure: load_ready_o only in LOAD; req_ready_o only in SERVE and
//          deasserted combinationally while load_start_i is high.
//
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   load_start_i                    (re)start a 16-bit table load
//   load_bit_i, load_valid_i        serial table bit and its qualifier
//   load_ready_o                    high while the block accepts load bits
//   a_i, b_i, c_i, d_i              query index, a_i is the MSB
//   req_valid_i, req_ready_o        query handshake
//   y_o, y_valid_o                  registered response and one-cycle qualifier
//   table_valid_o                   a complete table is loaded
//   resp_cnt_o                      responses since the last load (wraps)
module lut4_responder #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_start_i,
  input  logic             load_bit_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic             a_i,
  input  logic             b_i,
  input  logic             c_i,
  input  logic             d_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  output logic             y_o,
  output logic             y_valid_o,
  output logic             table_valid_o,
  output logic [CNT_W-1:0] resp_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SERVE = 2'd2
  } state_e;

  state_e             state_q;
  logic [3:0]         idx_q;
  logic [15:0]        table_q;
  logic               y_q;
  logic               y_valid_q;
  logic               table_valid_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [3:0]         idx_d;
  logic [CNT_W-1:0]   cnt_d;
  logic [3:0]         query_idx;
  logic               req_hs;
  logic               load_hs;

  assign query_idx = {a_i, b_i, c_i, d_i};
  assign idx_d     = idx_q + 4'd1;
  assign cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  // A load restart wins over both handshakes in the same cycle.
  assign load_ready_o = (state_q == ST_LOAD);
  assign req_ready_o  = (state_q == ST_SERVE) && !load_start_i;
  assign req_hs       = req_valid_i && req_ready_o;
  assign load_hs      = load_ready_o && load_valid_i && !load_start_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      idx_q         <= 4'd0;
      table_q       <= 16'h0000;
      y_q           <= 1'b0;
      y_valid_q     <= 1'b0;
      table_valid_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      y_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load_start_i) begin
            state_q       <= ST_LOAD;
            idx_q         <= 4'd0;
            table_valid_q <= 1'b0;
            cnt_q         <= '0;
          end
        end
        ST_LOAD: begin
          if (load_start_i) begin
            idx_q <= 4'd0;
          end else if (load_hs) begin
            table_q[idx_q] <= load_bit_i;
            idx_q          <= idx_d;
            // Index 15 is the last bit; idx_q wraps back to 0 for the next load.
            if (idx_q == 4'd15) begin
              state_q       <= ST_SERVE;
              table_valid_q <= 1'b1;
            end
          end
        end
        ST_SERVE: begin
          if (load_start_i) begin
            state_q       <= ST_LOAD;
            idx_q         <= 4'd0;
            table_valid_q <= 1'b0;
            cnt_q         <= '0;
          end else if (req_hs) begin
            y_q       <= table_q[query_idx];
            y_valid_q <= 1'b1;
            cnt_q     <= cnt_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign y_o           = y_q;
  assign y_valid_o     = y_valid_q;
  assign table_valid_o = table_valid_q;
  assign resp_cnt_o    = cnt_q;

endmodule

// File: tb/tb_lut4_responder.sv
// Bench for lut4_responder: table-driven directed vectors, hand sequences for
// reload/wrap/reset corners, and random traffic against a behavioural model.
module tb_lut4_responder;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       load_start_i = 1'b0;
  logic       load_bit_i = 1'b0;
  logic       load_valid_i = 1'b0;
  logic       load_ready_o;
  logic       a_i = 1'b0, b_i = 1'b0, c_i = 1'b0, d_i = 1'b0;
  logic       req_valid_i = 1'b0;
  logic       req_ready_o;
  logic       y_o;
  logic       y_valid_o;
  logic       table_valid_o;
  logic [7:0] resp_cnt_o;

  lut4_responder #(.CNT_W(8)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .load_start_i (load_start_i),
    .load_bit_i   (load_bit_i),
    .load_valid_i (load_valid_i),
    .load_ready_o (load_ready_o),
    .a_i          (a_i),
    .b_i          (b_i),
    .c_i          (c_i),
    .d_i          (d_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .y_o          (y_o),
    .y_valid_o    (y_valid_o),
    .table_valid_o(table_valid_o),
    .resp_cnt_o   (resp_cnt_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 = waiting for a load, 1 = collecting bits,
  // 2 = answering queries. Bits are kept in the order they arrive.
  int m_mode = 0;
  int m_nbits = 0;
  bit m_bits[16];
  bit m_y = 0, m_yv = 0, m_tv = 0;
  int m_cnt = 0;

  task automatic model_update(input bit rst, input bit ls, input bit lb, input bit lv,
                              input int q, input bit rv);
    if (rst) begin
      m_mode = 0; m_nbits = 0; m_y = 0; m_yv = 0; m_tv = 0; m_cnt = 0;
      foreach (m_bits[k]) m_bits[k] = 0;
    end else begin
      m_yv = 0;
      if (ls && m_mode != 0 || ls && m_mode == 0) begin
        // Any load_start from any state begins a fresh load.
        m_mode = 1; m_nbits = 0; m_tv = 0; m_cnt = 0;
      end else if (m_mode == 1 && lv) begin
        m_bits[m_nbits] = lb;
        m_nbits = m_nbits + 1;
        if (m_nbits == 16) begin
          m_mode = 2; m_tv = 1;
        end
      end else if (m_mode == 2 && rv) begin
        m_y = m_bits[q];
        m_yv = 1;
        m_cnt = (m_cnt + 1) % 256;
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model, check all outputs #1 after the edge.
  task automatic step(input bit rst, input bit ls, input bit lb, input bit lv,
                      input int q, input bit rv);
    rst_i = rst; load_start_i = ls; load_bit_i = lb; load_valid_i = lv;
    a_i = q[3]; b_i = q[2]; c_i = q[1]; d_i = q[0]; req_valid_i = rv;
    model_update(rst, ls, lb, lv, q, rv);
    @(posedge clk);
    #1;
    chk("y_valid", int'(y_valid_o), int'(m_yv));
    chk("y", int'(y_o), int'(m_y));
    chk("table_valid", int'(table_valid_o), int'(m_tv));
    chk("resp_cnt", int'(resp_cnt_o), m_cnt);
    chk("load_ready", int'(load_ready_o), int'(m_mode == 1));
    chk("req_ready", int'(req_ready_o), int'(m_mode == 2 && !ls));
    chk("ready_exclusive", int'(load_ready_o && req_ready_o), 0);
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic load16(input logic [15:0] v);
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, v[i], 1, 0, 0);
  endtask

  typedef struct {
    bit rst, ls, lb, lv, rv;
    int q;
    bit e_yv, e_y, e_tv;
    int e_cnt;
  } vec_t;

  function automatic vec_t mkv(bit rst, bit ls, bit lb, bit lv, int q, bit rv,
                               bit e_yv, bit e_y, bit e_tv, int e_cnt);
    vec_t v;
    v.rst = rst; v.ls = ls; v.lb = lb; v.lv = lv; v.q = q; v.rv = rv;
    v.e_yv = e_yv; v.e_y = e_y; v.e_tv = e_tv; v.e_cnt = e_cnt;
    return v;
  endfunction

  vec_t vecs[21];

  initial begin
    // Directed table: reset, load 16'h8000, query 1111 then 1110, then idle.
    vecs[0] = mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1] = mkv(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++)
      vecs[2+i] = mkv(0, 0, (i == 15), 1, 0, 0, 0, 0, (i == 15), 0);
    vecs[18] = mkv(0, 0, 0, 0, 15, 1, 1, 1, 1, 1);
    vecs[19] = mkv(0, 0, 0, 0, 14, 1, 1, 0, 1, 2);
    vecs[20] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 2);

    @(posedge clk); #1;
    // Stray inputs after reset while idle must do nothing.
    step(1, 0, 0, 0, 0, 0);
    chk("reset_load_ready", int'(load_ready_o), 0);
    chk("reset_req_ready", int'(req_ready_o), 0);
    step(0, 0, 1, 1, 5, 1);
    chk("idle_no_resp", int'(y_valid_o), 0);
    chk("idle_no_cnt", int'(resp_cnt_o), 0);

    for (int i = 0; i < 21; i++) begin
      step(vecs[i].rst, vecs[i].ls, vecs[i].lb, vecs[i].lv, vecs[i].q, vecs[i].rv);
      chk($sformatf("vec%0d_yv", i), int'(y_valid_o), int'(vecs[i].e_yv));
      chk($sformatf("vec%0d_y", i), int'(y_o), int'(vecs[i].e_y));
      chk($sformatf("vec%0d_tv", i), int'(table_valid_o), int'(vecs[i].e_tv));
      chk($sformatf("vec%0d_cnt", i), int'(resp_cnt_o), vecs[i].e_cnt);
    end

    // XOR4 table, back-to-back sweep.
    load16(16'h6996);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 0, i, 1);
      chk("xor_yv", int'(y_valid_o), 1);
      chk("xor_y", int'(y_o), $countones(i) % 2);
    end
    chk("xor_cnt", int'(resp_cnt_o), 16);

    // Reload after 8 bits: index restarts, table_valid waits for 16 new bits.
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, 1, 0, 0);
      chk("reload_tv", int'(table_valid_o), int'(i == 15));
    end
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 0, i, 1);
      chk("ones_y", int'(y_o), 1);
    end

    // Counter wrap: 257 responses leaves 1.
    load16(16'h1234);
    for (int i = 0; i < 257; i++) step(0, 0, 0, 0, i % 16, 1);
    chk("wrap_cnt", int'(resp_cnt_o), 1);
    step(0, 1, 0, 0, 3, 1);
    chk("start_blocks_req_yv", int'(y_valid_o), 0);
    chk("start_clears_cnt", int'(resp_cnt_o), 0);

    // Reset in the middle of a load.
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 0, 0);
    step(1, 0, 1, 1, 0, 1);
    chk("rst_load_yv", int'(y_valid_o), 0);
    chk("rst_load_tv", int'(table_valid_o), 0);
    chk("rst_load_rr", int'(req_ready_o), 0);

    // Reset in the cycle after a query: the pending pulse is killed.
    load16(16'hFFFF);
    step(0, 0, 0, 0, 7, 1);
    chk("pre_rst_yv", int'(y_valid_o), 1);
    step(1, 0, 0, 0, 7, 1);
    chk("rst_resp_yv", int'(y_valid_o), 0);
    chk("rst_resp_y", int'(y_o), 0);
    chk("rst_resp_tv", int'(table_valid_o), 0);
    chk("rst_resp_rr", int'(req_ready_o), 0);
    idle_step();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit r_rst, r_ls, r_lb, r_lv, r_rv;
      int r_q;
      r_rst = ($urandom % 300) == 0;
      r_ls  = ($urandom % 40) == 0;
      r_lb  = 1'($urandom % 2);
      r_lv  = ($urandom % 10) < 7;
      r_rv  = ($urandom % 10) < 7;
      r_q   = int'($urandom % 16);
      step(r_rst, r_ls, r_lb, r_lv, r_q, r_rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
